// File: rtl/alu_arbiter_if.sv
// Bus between the two requesters, the shared ALU and alu_arbiter.
// The slave modport is the arbiter side; master is the requester/ALU side.
`timescale 1ns/1ps

interface alu_arbiter_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic               i_req_0;
  logic [NB_DATA-1:0] i_dato_A_0;
  logic [NB_DATA-1:0] i_dato_B_0;
  logic [NB_OP-1:0]   i_op_0;
  logic               o_gnt_0;
  logic               o_done_0;

  logic               i_req_1;
  logic [NB_DATA-1:0] i_dato_A_1;
  logic [NB_DATA-1:0] i_dato_B_1;
  logic [NB_OP-1:0]   i_op_1;
  logic               o_gnt_1;
  logic               o_done_1;

  logic [NB_DATA-1:0] o_result;
  logic               o_busy;
  logic [NB_DATA-1:0] o_alu_A;
  logic [NB_DATA-1:0] o_alu_B;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] i_alu_result;

  modport slave (
    input  i_req_0, i_dato_A_0, i_dato_B_0, i_op_0,
    input  i_req_1, i_dato_A_1, i_dato_B_1, i_op_1,
    input  i_alu_result,
    output o_gnt_0, o_done_0, o_gnt_1, o_done_1,
    output o_result, o_busy, o_alu_A, o_alu_B, o_alu_op
  );

  modport master (
    output i_req_0, i_dato_A_0, i_dato_B_0, i_op_0,
    output i_req_1, i_dato_A_1, i_dato_B_1, i_op_1,
    output i_alu_result,
    input  o_gnt_0, o_done_0, o_gnt_1, o_done_1,
    input  o_result, o_busy, o_alu_A, o_alu_B, o_alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Round-robin by default; define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 first).
`timescale 1ns/1ps

module alu_arbiter #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input logic          i_clock,
  input logic          i_reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    EXEC = 3'b010,
    RESP = 3'b100
  } state_t;

  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic               lastServed_q, lastServed_d;
  logic [NB_DATA-1:0] aluA_q, aluA_d;
  logic [NB_DATA-1:0] aluB_q, aluB_d;
  logic [NB_OP-1:0]   aluOp_q, aluOp_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic               winner;

  always_comb begin
    winner = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    winner = ~bus.i_req_0;
`else
    // Under contention the requester not served last time goes next.
    if (bus.i_req_0 && bus.i_req_1) begin
      winner = ~lastServed_q;
    end else begin
      winner = ~bus.i_req_0;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    lastServed_d = lastServed_q;
    aluA_d       = aluA_q;
    aluB_d       = aluB_q;
    aluOp_d      = aluOp_q;
    result_d     = result_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req_0 || bus.i_req_1) begin
          sel_d   = winner;
          aluA_d  = winner ? bus.i_dato_A_1 : bus.i_dato_A_0;
          aluB_d  = winner ? bus.i_dato_B_1 : bus.i_dato_B_0;
          aluOp_d = winner ? bus.i_op_1 : bus.i_op_0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.i_alu_result;
        state_d  = RESP;
      end
      RESP: begin
        lastServed_d = sel_q;
        state_d      = IDLE;
      end
      default: begin
        aluA_d  = '0;
        aluB_d  = '0;
        aluOp_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      lastServed_q <= 1'b1;
      aluA_q       <= '0;
      aluB_q       <= '0;
      aluOp_q      <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      lastServed_q <= lastServed_d;
      aluA_q       <= aluA_d;
      aluB_q       <= aluB_d;
      aluOp_q      <= aluOp_d;
      result_q     <= result_d;
    end
  end

  // Grant and done are decoded from the registered state, so each lasts exactly one cycle.
  assign bus.o_gnt_0  = (state_q == EXEC) && !sel_q;
  assign bus.o_gnt_1  = (state_q == EXEC) &&  sel_q;
  assign bus.o_done_0 = (state_q == RESP) && !sel_q;
  assign bus.o_done_1 = (state_q == RESP) &&  sel_q;
  assign bus.o_busy   = (state_q != IDLE);
  assign bus.o_result = result_q;
  assign bus.o_alu_A  = aluA_q;
  assign bus.o_alu_B  = aluB_q;
  assign bus.o_alu_op = aluOp_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model and a done-pulse scoreboard.
// Build with ALU_ARB_FIXED_PRIO_EN defined to exercise the fixed-priority contention case.
`timescale 1ns/1ps

module tb_alu_arbiter;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;

  typedef struct {
    logic               idx;
    logic [NB_DATA-1:0] res;
  } expEntry_t;

  logic i_clock;
  logic i_reset;
  int   testsRun;
  int   testsFailed;
  int   doneCount0;
  int   doneCount1;
  expEntry_t expQ[$];

  alu_arbiter_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

  alu_arbiter #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Stand-in for the shared combinational ALU.
  always_comb begin
    bus.i_alu_result = '0;
    case (bus.o_alu_op)
      OP_ADD:  bus.i_alu_result = bus.o_alu_A + bus.o_alu_B;
      OP_SUB:  bus.i_alu_result = bus.o_alu_A - bus.o_alu_B;
      OP_AND:  bus.i_alu_result = bus.o_alu_A & bus.o_alu_B;
      OP_OR:   bus.i_alu_result = bus.o_alu_A | bus.o_alu_B;
      OP_XOR:  bus.i_alu_result = bus.o_alu_A ^ bus.o_alu_B;
      default: bus.i_alu_result = '0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic idx, input logic req,
                               input logic [NB_DATA-1:0] a, input logic [NB_DATA-1:0] b,
                               input logic [NB_OP-1:0] op);
    if (idx) begin
      bus.i_req_1 = req; bus.i_dato_A_1 = a; bus.i_dato_B_1 = b; bus.i_op_1 = op;
    end else begin
      bus.i_req_0 = req; bus.i_dato_A_0 = a; bus.i_dato_B_0 = b; bus.i_op_0 = op;
    end
  endtask

  task automatic pushExp(input logic idx, input logic [NB_DATA-1:0] res);
    expEntry_t e;
    e.idx = idx;
    e.res = res;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
    if (bus.o_done_0) doneCount0++;
    if (bus.o_done_1) doneCount1++;
  endtask

  task automatic applyReset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge i_clock) begin
    expEntry_t e;
    checkOutput("gntOneHot", 32'(bus.o_gnt_0 & bus.o_gnt_1), 32'h0);
    if (bus.o_done_0 || bus.o_done_1) begin
      checkOutput("doneOneHot", 32'(bus.o_done_0 & bus.o_done_1), 32'h0);
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDoneQueueSize", 32'(expQ.size()), 32'h1);
      end else begin
        e = expQ.pop_front();
        checkOutput("doneIdx", 32'(bus.o_done_1), 32'(e.idx));
        checkOutput("doneResult", 32'(bus.o_result), 32'(e.res));
      end
    end
  end

  initial begin
    testsRun = 0; testsFailed = 0; doneCount0 = 0; doneCount1 = 0;
    i_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 6'h00);
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 6'h00);
    tick();
    tick();
    checkOutput("rstBusy", 32'(bus.o_busy), 32'h0);
    checkOutput("rstGnt0", 32'(bus.o_gnt_0), 32'h0);
    checkOutput("rstGnt1", 32'(bus.o_gnt_1), 32'h0);
    checkOutput("rstDone0", 32'(bus.o_done_0), 32'h0);
    checkOutput("rstDone1", 32'(bus.o_done_1), 32'h0);
    checkOutput("rstResult", 32'(bus.o_result), 32'h0);
    checkOutput("rstAluA", 32'(bus.o_alu_A), 32'h0);
    checkOutput("rstAluB", 32'(bus.o_alu_B), 32'h0);
    checkOutput("rstAluOp", 32'(bus.o_alu_op), 32'h0);
    i_reset = 1'b0;

    // Single request from requester 0
    applyStimulus(1'b0, 1'b1, 8'h05, 8'h03, OP_ADD);
    pushExp(1'b0, 8'h08);
    tick();
    checkOutput("singleGnt0", 32'(bus.o_gnt_0), 32'h1);
    checkOutput("singleGnt1", 32'(bus.o_gnt_1), 32'h0);
    checkOutput("singleBusy1", 32'(bus.o_busy), 32'h1);
    checkOutput("singleAluA", 32'(bus.o_alu_A), 32'h05);
    checkOutput("singleAluB", 32'(bus.o_alu_B), 32'h03);
    checkOutput("singleAluOp", 32'(bus.o_alu_op), 32'(OP_ADD));
    applyStimulus(1'b0, 1'b0, 8'h05, 8'h03, OP_ADD);
    tick();
    checkOutput("singleDone0", 32'(bus.o_done_0), 32'h1);
    checkOutput("singleDone1", 32'(bus.o_done_1), 32'h0);
    checkOutput("singleGnt0Low", 32'(bus.o_gnt_0), 32'h0);
    checkOutput("singleBusy2", 32'(bus.o_busy), 32'h1);
    checkOutput("singleResult", 32'(bus.o_result), 32'h08);
    tick();
    checkOutput("singleIdleBusy", 32'(bus.o_busy), 32'h0);
    checkOutput("singleDoneLow", 32'(bus.o_done_0), 32'h0);
    checkOutput("singleResultHeld", 32'(bus.o_result), 32'h08);

    // Simultaneous first request after reset: 0 first, 1 granted at +4
    applyReset();
    applyStimulus(1'b0, 1'b1, 8'h0F, 8'h01, OP_SUB);
    applyStimulus(1'b1, 1'b1, 8'hF0, 8'h0F, OP_AND);
    pushExp(1'b0, 8'h0E);
    pushExp(1'b1, 8'h00);
    tick();
    checkOutput("simGnt0", 32'(bus.o_gnt_0), 32'h1);
    checkOutput("simGnt1Low", 32'(bus.o_gnt_1), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h0F, 8'h01, OP_SUB);
    tick();
    checkOutput("simResult0", 32'(bus.o_result), 32'h0E);
    tick();
    checkOutput("simIdle", 32'(bus.o_busy), 32'h0);
    tick();
    checkOutput("simGnt1", 32'(bus.o_gnt_1), 32'h1);
    checkOutput("simAluA1", 32'(bus.o_alu_A), 32'hF0);
    applyStimulus(1'b1, 1'b0, 8'hF0, 8'h0F, OP_AND);
    tick();
    checkOutput("simDone1", 32'(bus.o_done_1), 32'h1);
    checkOutput("simResult1", 32'(bus.o_result), 32'h00);
    tick();

    // Operand change after the grant must not reach the result
    applyStimulus(1'b0, 1'b1, 8'h21, 8'h12, OP_OR);
    pushExp(1'b0, 8'h33);
    tick();
    checkOutput("holdGnt0", 32'(bus.o_gnt_0), 32'h1);
    applyStimulus(1'b0, 1'b0, 8'hFF, 8'h12, OP_OR);
    tick();
    checkOutput("holdResult", 32'(bus.o_result), 32'h33);
    checkOutput("holdAluA", 32'(bus.o_alu_A), 32'h21);
    tick();

    // Sustained contention
    applyReset();
    doneCount0 = 0;
    doneCount1 = 0;
    applyStimulus(1'b0, 1'b1, 8'h0A, 8'h05, OP_XOR);
    applyStimulus(1'b1, 1'b1, 8'h30, 8'h03, OP_SUB);
`ifdef ALU_ARB_FIXED_PRIO_EN
    pushExp(1'b0, 8'h0F);
    pushExp(1'b0, 8'h0F);
    pushExp(1'b0, 8'h0F);
    pushExp(1'b1, 8'h2D);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checkOutput($sformatf("fixGnt0_%0d", k), 32'(bus.o_gnt_0), 32'((k % 3) == 1));
      checkOutput($sformatf("fixGnt1_%0d", k), 32'(bus.o_gnt_1), 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 8'h0A, 8'h05, OP_XOR);
    tick();
    checkOutput("fixGnt1After", 32'(bus.o_gnt_1), 32'h1);
    applyStimulus(1'b1, 1'b0, 8'h30, 8'h03, OP_SUB);
    tick();
    tick();
    checkOutput("fixDoneCount0", 32'(doneCount0), 32'd3);
    checkOutput("fixDoneCount1", 32'(doneCount1), 32'd1);
`else
    pushExp(1'b0, 8'h0F);
    pushExp(1'b1, 8'h2D);
    pushExp(1'b0, 8'h0F);
    pushExp(1'b1, 8'h2D);
    for (int k = 1; k <= 12; k++) begin
      tick();
      checkOutput($sformatf("rrGnt0_%0d", k), 32'(bus.o_gnt_0),
                  32'(((k % 3) == 1) && (((k / 3) % 2) == 0)));
      checkOutput($sformatf("rrGnt1_%0d", k), 32'(bus.o_gnt_1),
                  32'(((k % 3) == 1) && (((k / 3) % 2) == 1)));
    end
    applyStimulus(1'b0, 1'b0, 8'h0A, 8'h05, OP_XOR);
    applyStimulus(1'b1, 1'b0, 8'h30, 8'h03, OP_SUB);
    tick();
    checkOutput("rrDoneCount0", 32'(doneCount0), 32'd2);
    checkOutput("rrDoneCount1", 32'(doneCount1), 32'd2);
    checkOutput("rrIdle", 32'(bus.o_busy), 32'h0);
`endif

    // Serve requester 0 so that only reset can restore the initial round-robin pointer
    applyStimulus(1'b0, 1'b1, 8'h02, 8'h03, OP_ADD);
    pushExp(1'b0, 8'h05);
    tick();
    checkOutput("preRstGnt0", 32'(bus.o_gnt_0), 32'h1);
    applyStimulus(1'b0, 1'b0, 8'h02, 8'h03, OP_ADD);
    tick();
    tick();

    // Reset during EXEC of a requester-1 operation
    applyStimulus(1'b1, 1'b1, 8'h44, 8'h11, OP_ADD);
    tick();
    checkOutput("midGnt1", 32'(bus.o_gnt_1), 32'h1);
    i_reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h44, 8'h11, OP_ADD);
    tick();
    checkOutput("midBusy", 32'(bus.o_busy), 32'h0);
    checkOutput("midDone0", 32'(bus.o_done_0), 32'h0);
    checkOutput("midDone1", 32'(bus.o_done_1), 32'h0);
    checkOutput("midResult", 32'(bus.o_result), 32'h0);
    checkOutput("midAluA", 32'(bus.o_alu_A), 32'h0);
    i_reset = 1'b0;
    tick();
    checkOutput("midNoDoneLater", 32'(bus.o_done_1), 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h09, 8'h04, OP_SUB);
    applyStimulus(1'b1, 1'b1, 8'h0C, 8'h0A, OP_AND);
    pushExp(1'b0, 8'h05);
    tick();
    checkOutput("postRstGnt0", 32'(bus.o_gnt_0), 32'h1);
    checkOutput("postRstGnt1", 32'(bus.o_gnt_1), 32'h0);
    applyStimulus(1'b0, 1'b0, 8'h09, 8'h04, OP_SUB);
    applyStimulus(1'b1, 1'b0, 8'h0C, 8'h0A, OP_AND);
    tick();
    checkOutput("postRstResult", 32'(bus.o_result), 32'h05);
    tick();

    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
